// File: rtl/spi_cmd_dispatch_pkg.sv
// Shared types and constants for the SPI command dispatcher: FSM encoding,
// queued frame layout and well-known command codes.
package spi_dispatch_pkg;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_ASSEMBLE = 1'b1
    } state_t;

    // One queued frame: command, right-aligned payload, byte count, overflow flag.
    typedef struct packed {
        logic [7:0]  cmd;
        logic [31:0] data;
        logic [2:0]  len;
        logic        trunc;
    } frame_t;

    localparam int ENTRY_W = 8 + 32 + 3 + 1;

    localparam logic [7:0] CMD_BUTTONS = 8'hF4;

    function automatic logic [31:0] payload_mask(input int bytes);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < bytes) m[i*8 +: 8] = 8'hFF;
        end
        return m;
    endfunction

endpackage

// File: rtl/spi_cmd_dispatch_if.sv
// Byte stream from the SPI protocol layer and the frame handshake to the
// consumer; the dispatcher sits on the slave modport.
interface spi_cmd_dispatch_if;

    logic [7:0]  pw_wdata;
    logic        pw_wcmd;
    logic        pw_wstb;
    logic        pw_end;

    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_cmd;
    logic [31:0] out_data;
    logic [2:0]  out_len;
    logic        out_trunc;

    modport slave (
        input  pw_wdata, pw_wcmd, pw_wstb, pw_end, out_ready,
        output out_valid, out_cmd, out_data, out_len, out_trunc
    );

    modport master (
        output pw_wdata, pw_wcmd, pw_wstb, pw_end, out_ready,
        input  out_valid, out_cmd, out_data, out_len, out_trunc
    );

endinterface

// File: rtl/spi_cmd_dispatch_frame_fifo.sv
// Completed-frame queue: register array with wrap-bit pointers. A push into a
// full queue is accepted when a pop happens in the same cycle.
module frame_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int        AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd_en = i_pop && !o_empty;
    assign w_wr_en = i_push && (!o_full || w_rd_en);
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; pointers define validity and
    // the top masks the head while the queue is empty.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/spi_cmd_dispatch.sv
// Assembles command frames from the SPI byte stream and queues them for a
// ready/valid consumer; frames arriving at a full queue are counted as drops.
module spi_cmd_dispatch
    import spi_dispatch_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int PAYLOAD_BYTES = 4
) (
    input  logic                clk,
    input  logic                resetq,
    spi_cmd_dispatch_if.slave   bus,
    output logic [7:0]          drop_cnt,
    output logic                busy
);

    localparam logic [2:0]  LEN_MAX   = 3'(PAYLOAD_BYTES);
    localparam logic [31:0] DATA_MASK = payload_mask(PAYLOAD_BYTES);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cmd, w_cmd_nxt;
    logic [31:0] r_data, w_data_nxt;
    logic [2:0]  r_len, w_len_nxt;
    logic        r_trunc, w_trunc_nxt;
    logic [7:0]  r_drop;
    logic        w_push, w_pop, w_full, w_empty;
    frame_t      w_frame, w_head;
    logic [ENTRY_W-1:0] w_dout;

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_nxt   = r_cmd;
        w_data_nxt  = r_data;
        w_len_nxt   = r_len;
        w_trunc_nxt = r_trunc;
        w_push      = 1'b0;

        if (bus.pw_wstb && bus.pw_wcmd) begin
            w_state_nxt = ST_ASSEMBLE;
            w_cmd_nxt   = bus.pw_wdata;
            w_data_nxt  = '0;
            w_len_nxt   = '0;
            w_trunc_nxt = 1'b0;
        end else if (bus.pw_wstb && r_state == ST_ASSEMBLE) begin
            w_data_nxt = {r_data[23:0], bus.pw_wdata} & DATA_MASK;
            if (r_len == LEN_MAX) w_trunc_nxt = 1'b1;
            else                  w_len_nxt   = r_len + 3'd1;
        end

        // A byte coinciding with end-of-frame is absorbed before the close.
        if (bus.pw_end && w_state_nxt == ST_ASSEMBLE) begin
            w_push      = 1'b1;
            w_state_nxt = ST_IDLE;
        end

        w_frame = '{cmd: w_cmd_nxt, data: w_data_nxt, len: w_len_nxt, trunc: w_trunc_nxt};
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_data  <= '0;
            r_len   <= '0;
            r_trunc <= 1'b0;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cmd   <= w_cmd_nxt;
            r_data  <= w_data_nxt;
            r_len   <= w_len_nxt;
            r_trunc <= w_trunc_nxt;
            if (w_push && w_full && !w_pop && r_drop != 8'hFF)
                r_drop <= r_drop + 8'd1;
        end
    end

    frame_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetq  (resetq),
        .i_push  (w_push),
        .i_din   (w_frame),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop  = !w_empty && bus.out_ready;
    assign w_head = frame_t'(w_dout);

    assign bus.out_valid = !w_empty;
    assign bus.out_cmd   = w_empty ? '0   : w_head.cmd;
    assign bus.out_data  = w_empty ? '0   : w_head.data;
    assign bus.out_len   = w_empty ? '0   : w_head.len;
    assign bus.out_trunc = w_empty ? 1'b0 : w_head.trunc;

    assign drop_cnt = r_drop;
    assign busy     = (r_state == ST_ASSEMBLE);

endmodule
